// File: rtl/top_level_pkg.sv
`default_nettype none
// ============================================================================
// Module   : top_level_pkg
// Purpose  : Shared constants, FSM state and status codes for the SECDED
//            (16,11) decoder engine.
// Revision : 1.0 - initial release
// ============================================================================
package top_level_pkg;

    // Number of codewords processed per program run
    localparam int NUM_WORDS = 15;
    // Byte address of the first input codeword (low byte)
    localparam int IN_BASE   = 30;
    // Byte address of the first output word (low byte)
    localparam int OUT_BASE  = 0;
    // Data memory depth in bytes
    localparam int MEM_DEPTH = 256;
    // Data memory address width
    localparam int ADDR_W    = 8;

    // Controller states
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_LO = 3'd1,
        RD_HI = 3'd2,
        WR_LO = 3'd3,
        WR_HI = 3'd4,
        DONE  = 3'd5
    } state_t;

    // Status tag placed in result bits 15:14
    typedef enum logic [1:0] {
        STAT_OK  = 2'b00,
        STAT_SGL = 2'b01,
        STAT_DBL = 2'b10
    } status_t;

endpackage : top_level_pkg
`default_nettype wire

// File: rtl/top_level_mem.sv
`default_nettype none
// ============================================================================
// Module   : data_mem
// Purpose  : Single-port byte memory, combinational read, synchronous write.
//            Contents are deliberately not reset so a preload survives reset.
// Revision : 1.0 - initial release
// ============================================================================
module data_mem #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [7:0]    wdata_i,
    output logic [7:0]    rdata_o
);

    logic [7:0] core [DEPTH];

    assign rdata_o = core[addr_i];

    // One byte write per cycle when enabled
    always_ff @(posedge clk) begin
        if (we_i) begin
            core[addr_i] <= wdata_i;
        end
    end

endmodule : data_mem
`default_nettype wire

// File: rtl/top_level.sv
`default_nettype none
// ============================================================================
// Module   : top_level
// Purpose  : Self-contained SECDED (extended Hamming 16,11) decoder. After
//            reset it reads NUM_WORDS codewords from dm1, corrects single
//            errors, flags double errors, writes tagged 11-bit messages back
//            and then raises done. Four cycles per word.
// Revision : 1.0 - initial release
// ============================================================================
module top_level
    import top_level_pkg::*;
(
    input  logic clk,
    input  logic reset,
    output logic done
);

    // Output area must sit entirely below the input area
    localparam int LAST_IDX = NUM_WORDS - 1;

    // Controller registers; power-up values keep done low before first reset
    state_t      state_q = IDLE;
    logic        done_q  = 1'b0;
    logic [3:0]  idx_q;
    logic [3:0]  idx_d;
    logic [7:0]  lo_q;
    logic [7:0]  hi_q;

    // Memory interface
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;

    // Decoder signals
    logic [15:0] cw;
    logic [3:0]  syn;
    logic        par;
    logic [15:0] fixed;
    logic [10:0] data;
    status_t     status;
    logic [15:0] result;

    logic [ADDR_W-1:0] word_off;

    assign idx_d    = idx_q + 4'd1;
    assign word_off = {3'b000, idx_q, 1'b0};
    assign cw       = {hi_q, lo_q};
    assign done     = done_q;

    data_mem #(
        .DEPTH (MEM_DEPTH),
        .AW    (ADDR_W)
    ) dm1 (
        .clk     (clk),
        .we_i    (mem_we),
        .addr_i  (mem_addr),
        .wdata_i (mem_wdata),
        .rdata_o (mem_rdata)
    );

    // SECDED decode of the latched codeword: syndrome, parity, correction
    always_comb begin
        syn = 4'd0;
        for (int k = 1; k < 16; k++) begin
            if (cw[k]) begin
                syn = syn ^ 4'(k);
            end
        end
        par   = ^cw;
        fixed = cw;
        // With odd overall parity the syndrome points at the bad bit; zero means p0
        if (par) begin
            fixed[syn] = ~cw[syn];
        end
        data = {fixed[15:9], fixed[7:5], fixed[3]};
        if (par) begin
            status = STAT_SGL;
        end else if (syn != 4'd0) begin
            status = STAT_DBL;
        end else begin
            status = STAT_OK;
        end
        result = {status, 3'b000, data};
    end

    // Memory address / write steering from the current state
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = 8'h00;
        case (state_q)
            RD_LO: mem_addr = ADDR_W'(IN_BASE) + word_off;
            RD_HI: mem_addr = ADDR_W'(IN_BASE) + word_off + 8'd1;
            WR_LO: begin
                mem_addr  = ADDR_W'(OUT_BASE) + word_off;
                mem_wdata = result[7:0];
                mem_we    = ~reset;
            end
            WR_HI: begin
                mem_addr  = ADDR_W'(OUT_BASE) + word_off + 8'd1;
                mem_wdata = result[15:8];
                mem_we    = ~reset;
            end
            default: mem_addr = '0;
        endcase
    end

    // Program sequencer: read two bytes, write two bytes, per word
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RD_LO;
            idx_q   <= 4'd0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: state_q <= IDLE;
                RD_LO: begin
                    lo_q    <= mem_rdata;
                    state_q <= RD_HI;
                end
                RD_HI: begin
                    hi_q    <= mem_rdata;
                    state_q <= WR_LO;
                end
                WR_LO: state_q <= WR_HI;
                WR_HI: begin
                    idx_q <= idx_d;
                    if (idx_q == 4'(LAST_IDX)) begin
                        state_q <= DONE;
                    end else begin
                        state_q <= RD_LO;
                    end
                end
                DONE: done_q <= 1'b1;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule : top_level
`default_nettype wire

// File: tb/tb_top_level.sv
`default_nettype none
// ============================================================================
// Module   : tb_top_level
// Purpose  : Self-checking bench for the SECDED decoder engine: behavioural
//            decode model, per-cycle done timing check, memory result checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_top_level;
    import top_level_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic done;

    top_level dut (
        .clk   (clk),
        .reset (reset),
        .done  (done)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    logic [15:0] in_words [NUM_WORDS];

    // Edges since reset was last sampled high
    int cyc        = 0;
    bit seen_reset = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            cyc        <= 0;
            seen_reset <= 1'b1;
        end else if (cyc < 100000) begin
            cyc <= cyc + 1;
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // done must be low until the 61st edge after reset, then stay high
    always @(negedge clk) begin
        logic exp_done;
        exp_done = seen_reset && (cyc >= 61);
        check("done", {15'd0, done}, {15'd0, exp_done});
    end

    function automatic bit is_pow2(input int k);
        return (k & (k - 1)) == 0;
    endfunction

    // Reference decode from the Hamming rules
    function automatic logic [15:0] model_decode(input logic [15:0] c);
        int          s;
        int          p;
        int          j;
        logic [15:0] f;
        logic [10:0] d;
        logic [1:0]  st;
        s = 0;
        p = 0;
        for (int k = 0; k < 16; k++) begin
            if (c[k]) begin
                p = p ^ 1;
                s = s ^ k;
            end
        end
        f = c;
        if (p == 1) f[s] = ~f[s];
        d = '0;
        j = 0;
        for (int k = 1; k < 16; k++) begin
            if (!is_pow2(k)) begin
                d[j] = f[k];
                j++;
            end
        end
        if (p == 1)      st = 2'b01;
        else if (s != 0) st = 2'b10;
        else             st = 2'b00;
        return {st, 3'b000, d};
    endfunction

    function automatic logic [15:0] encode(input logic [10:0] d);
        logic [15:0] c;
        logic [3:0]  s;
        int          j;
        c = '0;
        j = 0;
        for (int k = 1; k < 16; k++) begin
            if (!is_pow2(k)) begin
                c[k] = d[j];
                j++;
            end
        end
        s = 4'd0;
        for (int k = 1; k < 16; k++) begin
            if (c[k]) s = s ^ 4'(k);
        end
        c[1] = s[0];
        c[2] = s[1];
        c[4] = s[2];
        c[8] = s[3];
        c[0] = ^c[15:1];
        return c;
    endfunction

    task automatic load_inputs();
        for (int i = 0; i < NUM_WORDS; i++) begin
            dut.dm1.core[IN_BASE + 2*i]     = in_words[i][7:0];
            dut.dm1.core[IN_BASE + 2*i + 1] = in_words[i][15:8];
        end
    endtask

    task automatic fill_outputs(input logic [7:0] v);
        for (int i = 0; i < 2*NUM_WORDS; i++) begin
            dut.dm1.core[OUT_BASE + i] = v;
        end
    endtask

    task automatic gen_random();
        int a;
        int b;
        logic [15:0] c;
        for (int i = 0; i < NUM_WORDS; i++) begin
            c = encode(11'($urandom));
            a = $urandom_range(15, 0);
            c[a] = ~c[a];
            if ($urandom_range(3, 0) == 0) begin
                b = (a + 1 + $urandom_range(14, 0)) % 16;
                c[b] = ~c[b];
            end
            in_words[i] = c;
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (!done && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("done_timeout", {15'd0, done}, 16'd1);
        repeat (5) @(negedge clk);
    endtask

    task automatic check_results(input string tag);
        logic [15:0] act;
        logic [15:0] inp;
        for (int i = 0; i < NUM_WORDS; i++) begin
            act = {dut.dm1.core[OUT_BASE + 2*i + 1], dut.dm1.core[OUT_BASE + 2*i]};
            check($sformatf("%s_res%0d", tag, i), act, model_decode(in_words[i]));
            inp = {dut.dm1.core[IN_BASE + 2*i + 1], dut.dm1.core[IN_BASE + 2*i]};
            check($sformatf("%s_in%0d", tag, i), inp, in_words[i]);
        end
    endtask

    initial begin
        logic [15:0] v;

        // Model pinned against hand-derived values
        check("model_clean", model_decode(16'hFFFF), 16'h07FF);
        check("model_p0",    model_decode(16'hFFFE), 16'h47FF);
        check("model_d1",    model_decode(16'hFFF7), 16'h47FF);
        check("model_dbl",   model_decode(16'hFFD7), 16'h87FC);
        check("model_enc",   encode(11'h7FF),        16'hFFFF);

        repeat (3) @(negedge clk);

        // All-zero codewords
        for (int i = 0; i < NUM_WORDS; i++) in_words[i] = 16'h0000;
        load_inputs();
        fill_outputs(8'hA5);
        pulse_reset();
        wait_done();
        check_results("zero");
        v = {dut.dm1.core[OUT_BASE + 1], dut.dm1.core[OUT_BASE]};
        check("zero_lit", v, 16'h0000);

        // Hand-picked codewords in the first slots, random in the rest
        gen_random();
        in_words[0] = 16'hFFFF;
        in_words[1] = 16'hFFFE;
        in_words[2] = 16'hFFF7;
        in_words[3] = 16'hFFD7;
        load_inputs();
        fill_outputs(8'h5A);
        pulse_reset();
        wait_done();
        check_results("lit");
        v = {dut.dm1.core[OUT_BASE + 1], dut.dm1.core[OUT_BASE + 0]};
        check("lit_clean", v, 16'h07FF);
        v = {dut.dm1.core[OUT_BASE + 3], dut.dm1.core[OUT_BASE + 2]};
        check("lit_p0", v, 16'h47FF);
        v = {dut.dm1.core[OUT_BASE + 5], dut.dm1.core[OUT_BASE + 4]};
        check("lit_d1", v, 16'h47FF);
        v = {dut.dm1.core[OUT_BASE + 7], dut.dm1.core[OUT_BASE + 6]};
        check("lit_dbl", v, 16'h87FC);

        // Random runs
        for (int r = 0; r < 3; r++) begin
            gen_random();
            load_inputs();
            fill_outputs(8'h3C);
            pulse_reset();
            wait_done();
            check_results($sformatf("rnd%0d", r));
        end

        // Reset again while word 7 is in flight
        gen_random();
        load_inputs();
        fill_outputs(8'h55);
        pulse_reset();
        begin
            int t;
            t = 0;
            while (cyc < 30 && t < 200) begin
                @(negedge clk);
                t++;
            end
            check("mid_reach", {15'd0, (cyc >= 30)}, 16'd1);
        end
        v = {dut.dm1.core[OUT_BASE + 1], dut.dm1.core[OUT_BASE]};
        check("mid_word0", v, model_decode(in_words[0]));
        pulse_reset();
        wait_done();
        check_results("mid");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_top_level
`default_nettype wire
